// File: rtl/cic_iq_decimator.sv
// Three-stage I/Q CIC decimator with a runtime power-of-two ratio, unity gain, round and saturate.
// Latency 4 clocks from the decimating in_valid to out_valid; there is no backpressure.
module cic_iq_decimator #(
    parameter int DSZ      = 16,
    parameter int N        = 3,
    parameter int MAX_LOG2 = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [DSZ-1:0] in_i,
    input  logic [DSZ-1:0] in_q,
    input  logic [2:0]     dec_log2,
    output logic           out_valid,
    output logic [DSZ-1:0] out_i,
    output logic [DSZ-1:0] out_q
);

    localparam int W  = DSZ + N * MAX_LOG2;
    localparam int SW = $clog2(N * MAX_LOG2 + 1);
    localparam logic signed [W:0] SAT_MAX = (W+1)'((2 ** (DSZ - 1)) - 1);
    localparam logic signed [W:0] SAT_MIN = -SAT_MAX - (W+1)'(1);

    function automatic logic [2:0] clamp_log2(input logic [2:0] v);
        if (v == 3'd0)
            return 3'd1;
        if (int'(v) > MAX_LOG2)
            return 3'(MAX_LOG2);
        return v;
    endfunction

    logic [W-1:0]          integ_q [2][N];
    logic [W-1:0]          comb_q  [2][N];
    logic [W-1:0]          dly_q   [2][N];
    logic [W-1:0]          s_q     [2];
    logic [N:0]            vld_q;
    logic [MAX_LOG2-1:0]   cnt_q;
    logic [2:0]            r_log2_q;
    logic [2:0]            r_out_q;

    logic [DSZ-1:0]        din     [2];
    logic [MAX_LOG2-1:0]   term_d;
    logic                  fire_d;
    logic [SW-1:0]         shamt_d;
    logic signed [W:0]     rnd_d   [2];
    logic signed [W:0]     shf_d   [2];
    logic [DSZ-1:0]        res_d   [2];

    assign din[0] = in_i;
    assign din[1] = in_q;

    always_comb begin
        term_d = ~({MAX_LOG2{1'b1}} << r_log2_q);
        fire_d = in_valid && (cnt_q == term_d);
    end

    // r_out_q holds the ratio of the period currently in the comb pipeline.
    always_comb begin
        shamt_d = SW'(N) * SW'(r_out_q);
        for (int ch = 0; ch < 2; ch++) begin
            rnd_d[ch] = $signed({comb_q[ch][N-1][W-1], comb_q[ch][N-1]})
                      + $signed((W+1)'(1) << (shamt_d - SW'(1)));
            shf_d[ch] = rnd_d[ch] >>> shamt_d;
            if (shf_d[ch] > SAT_MAX)
                res_d[ch] = SAT_MAX[DSZ-1:0];
            else if (shf_d[ch] < SAT_MIN)
                res_d[ch] = SAT_MIN[DSZ-1:0];
            else
                res_d[ch] = shf_d[ch][DSZ-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            r_log2_q  <= clamp_log2(dec_log2);
            r_out_q   <= clamp_log2(dec_log2);
            vld_q     <= '0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                s_q[ch] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ_q[ch][k] <= '0;
                    comb_q[ch][k]  <= '0;
                    dly_q[ch][k]   <= '0;
                end
            end
        end else begin
            vld_q     <= {vld_q[N-1:0], fire_d};
            out_valid <= vld_q[N];

            if (in_valid) begin
                cnt_q <= fire_d ? '0 : cnt_q + MAX_LOG2'(1);
                for (int ch = 0; ch < 2; ch++) begin
                    integ_q[ch][0] <= integ_q[ch][0] + W'($signed(din[ch]));
                    for (int k = 1; k < N; k++)
                        integ_q[ch][k] <= integ_q[ch][k] + integ_q[ch][k-1];
                end
            end

            if (fire_d) begin
                r_log2_q <= clamp_log2(dec_log2);
                r_out_q  <= r_log2_q;
                for (int ch = 0; ch < 2; ch++)
                    s_q[ch] <= integ_q[ch][N-1];
            end

            for (int ch = 0; ch < 2; ch++) begin
                if (vld_q[0]) begin
                    comb_q[ch][0] <= s_q[ch] - dly_q[ch][0];
                    dly_q[ch][0]  <= s_q[ch];
                end
                for (int k = 1; k < N; k++) begin
                    if (vld_q[k]) begin
                        comb_q[ch][k] <= comb_q[ch][k-1] - dly_q[ch][k];
                        dly_q[ch][k]  <= comb_q[ch][k-1];
                    end
                end
            end

            if (vld_q[N]) begin
                out_i <= res_d[0];
                out_q <= res_d[1];
            end
        end
    end

endmodule

// File: tb/tb_cic_iq_decimator.sv
// Directed bench for cic_iq_decimator; a closed-form CIC model predicts every output cycle.
module tb_cic_iq_decimator;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [15:0] in_i = '0;
    logic signed [15:0] in_q = '0;
    logic [2:0]        dec_log2 = 3'd3;
    logic              out_valid;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;

    cic_iq_decimator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_i      (in_i),
        .in_q      (in_q),
        .dec_log2  (dec_log2),
        .out_valid (out_valid),
        .out_i     (out_i),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 due;
        bit                 rst;
        logic signed [15:0] i;
        logic signed [15:0] q;
    } exp_t;

    exp_t    expq[$];
    longint  hist_i[$], hist_q[$];
    longint  s_i[$], s_q[$];
    int      cnt_m = 0;
    int      r_cur = 3;
    int      checks = 0;
    int      failures = 0;
    int      nvld = 0;
    logic signed [15:0] last_i = '0, last_q = '0;
    logic signed [15:0] mdl_i = '0, mdl_q = '0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int clampr(input int v);
        if (v == 0) return 1;
        if (v > 6) return 6;
        return v;
    endfunction

    // Third integrator before the n-th input: sum of x[i] * C(n-1-i, 2).
    function automatic longint int3pre(input longint h[$]);
        longint acc = 0;
        int n = h.size();
        for (int i = 0; i < n; i++) begin
            longint m = n - 1 - i;
            acc += h[i] * ((m * (m - 1)) / 2);
        end
        return acc;
    endfunction

    // Third difference of the captured samples, modulo 2^34, then round and saturate.
    function automatic logic signed [15:0] model_out(input longint s[$], input int r);
        longint v[4];
        longint y;
        int sz = s.size();
        int sh;
        for (int k = 0; k < 4; k++)
            v[k] = (sz - 1 - k >= 0) ? s[sz-1-k] : 0;
        y  = v[0] - 3 * v[1] + 3 * v[2] - v[3];
        y  = (y <<< 30) >>> 30;
        sh = 3 * r;
        y  = (y + (longint'(1) <<< (sh - 1))) >>> sh;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return 16'(y);
    endfunction

    task automatic send(input int xi, input int xq, input int gap = 1);
        exp_t e;
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_i = 16'(xi);
        in_q = 16'(xq);
        cnt_m++;
        if (cnt_m == (1 << r_cur)) begin
            s_i.push_back(int3pre(hist_i));
            s_q.push_back(int3pre(hist_q));
            e.due = cyc + 5;
            e.rst = 1'b0;
            e.i   = model_out(s_i, r_cur);
            e.q   = model_out(s_q, r_cur);
            mdl_i = e.i;
            mdl_q = e.q;
            expq.push_back(e);
            cnt_m = 0;
            r_cur = clampr(int'(dec_log2));
        end
        hist_i.push_back(longint'(xi));
        hist_q.push_back(longint'(xq));
        repeat (gap) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input int dec);
        exp_t keep[$];
        exp_t e;
        @(posedge clk); #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        dec_log2 = 3'(dec);
        foreach (expq[j])
            if (expq[j].due <= cyc) keep.push_back(expq[j]);
        expq = keep;
        e.due = cyc + 1;
        e.rst = 1'b1;
        e.i   = '0;
        e.q   = '0;
        expq.push_back(e);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        hist_i.delete();
        hist_q.delete();
        s_i.delete();
        s_q.delete();
        cnt_m = 0;
        r_cur = clampr(dec);
    endtask

    task automatic flush(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Per-cycle compare against the model's schedule of outputs and resets.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                while (expq.size() > 0 && expq[0].due < cyc) begin
                    e = expq.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_output: due cycle %0d not seen by cycle %0d", e.due, cyc);
                end
                if (expq.size() > 0 && expq[0].due == cyc) begin
                    e = expq.pop_front();
                    if (e.rst) begin
                        chk("rst_out_valid", out_valid, 0);
                        chk("rst_out_i", out_i, 0);
                        chk("rst_out_q", out_q, 0);
                        last_i = '0;
                        last_q = '0;
                    end else begin
                        chk("out_valid", out_valid, 1);
                        chk("out_i", out_i, e.i);
                        chk("out_q", out_q, e.q);
                        last_i = e.i;
                        last_q = e.q;
                    end
                end else begin
                    chk("idle_out_valid", out_valid, 0);
                    chk("hold_out_i", out_i, last_i);
                    chk("hold_out_q", out_q, last_q);
                end
                if (out_valid === 1'b1) nvld++;
            end
        end
    end

    initial begin
        exp_t e0;
        int   n0;
        e0.due = 1; e0.rst = 1'b1; e0.i = '0; e0.q = '0;
        expq.push_back(e0);
        dec_log2 = 3'd3;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        r_cur = 3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_i", out_i, 0);

        // DC gain and strobe count at R=8
        n0 = nvld;
        for (int j = 0; j < 64; j++) send(1000, -1000);
        flush(8);
        chk("r8_strobe_count", nvld - n0, 8);
        chk("dc_out_i", out_i, 1000);
        chk("dc_out_q", out_q, -1000);
        chk("model_dc_i", mdl_i, 1000);

        // Ratio 3 -> 1 mid-period
        n0 = nvld;
        for (int j = 0; j < 4; j++) send(1000, -1000);
        dec_log2 = 3'd1;
        for (int j = 0; j < 12; j++) send(1000, -1000);
        flush(8);
        chk("ratio_change_count", nvld - n0, 5);
        chk("ratio_change_dc_i", out_i, 1000);

        // dec_log2 = 0 behaves as R=2
        do_reset(0);
        n0 = nvld;
        for (int j = 0; j < 16; j++) send(3, -3);
        flush(8);
        chk("r2_strobe_count", nvld - n0, 8);
        chk("dc3_out_i", out_i, 3);
        chk("dc3_out_q", out_q, -3);

        // dec_log2 = 7 behaves as R=64, full scale then step
        do_reset(7);
        n0 = nvld;
        for (int j = 0; j < 320; j++) send(32767, -32768);
        flush(8);
        chk("r64_strobe_count", nvld - n0, 5);
        chk("fs_out_i", out_i, 32767);
        chk("fs_out_q", out_q, -32768);
        chk("model_fs_i", mdl_i, 32767);
        for (int j = 0; j < 256; j++) send(-32768, -32768);
        flush(8);
        chk("step_out_i", out_i, -32768);

        // Reset two clocks after a decimating input
        do_reset(3);
        for (int j = 0; j < 24; j++) send(500, 500);
        n0 = nvld;
        do_reset(3);
        chk("midrst_out_i", out_i, 0);
        chk("midrst_out_q", out_q, 0);
        flush(6);
        chk("midrst_no_strobe", nvld - n0, 0);
        for (int j = 0; j < 64; j++) send(500, 500);
        flush(8);
        chk("reconverge_out_i", out_i, 500);
        chk("model_reconverge", mdl_i, 500);

        // R=2 full-scale I with alternating extremes on Q
        do_reset(1);
        for (int j = 0; j < 32; j++) send(32767, (j % 2 != 0) ? 32767 : -32768);
        flush(8);
        chk("r2_fs_out_i", out_i, 32767);

        flush(10);
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
